// File: rtl/cp0_irq_ctrl_pkg.sv
// Shared definitions for the CP0 exception/interrupt controller:
// register select codes, register bit positions and the EPC stack entry layout.
package cp0_irq_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        CP0_SEL_STATUS = 2'd0,
        CP0_SEL_CAUSE  = 2'd1,
        CP0_SEL_EPC    = 2'd2,
        CP0_SEL_DEPTH  = 2'd3
    } cp0_sel_e;

    localparam int STATUS_IE_BIT   = 0;
    localparam int STATUS_MASK_LSB = 16;
    localparam int CAUSE_PRIO_LSB  = 24;
    localparam int CAUSE_ERR_BIT   = 31;

    typedef struct packed {
        logic [XLEN-1:0] epc;
        logic [3:0]      prio;
    } stack_entry_t;

    // Handler entry point for a source: one fixed-size slot per source above the base.
    function automatic logic [XLEN-1:0] vec_addr(input logic [XLEN-1:0] base,
                                                 input int              shift,
                                                 input logic [3:0]      id);
        return base + (XLEN'(id) << shift);
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// Core-side bus of the CP0 controller: PC-select outputs, eret/block controls
// and the mtc0/mfc0 register port.
interface cp0_irq_ctrl_if;
    import cp0_irq_ctrl_pkg::*;

    logic            exp_block;
    logic            eret_i;
    logic [XLEN-1:0] pc_next_i;
    logic            cp0_we;
    cp0_sel_e        cp0_sel;
    logic [XLEN-1:0] cp0_wdata;
    logic [XLEN-1:0] cp0_rdata;
    logic            exc_take;
    logic            exc_eret;
    logic [3:0]      exc_id;
    logic [XLEN-1:0] target_pc;

    modport master (
        output exp_block, eret_i, pc_next_i, cp0_we, cp0_sel, cp0_wdata,
        input  cp0_rdata, exc_take, exc_eret, exc_id, target_pc
    );

    modport slave (
        input  exp_block, eret_i, pc_next_i, cp0_we, cp0_sel, cp0_wdata,
        output cp0_rdata, exc_take, exc_eret, exc_id, target_pc
    );

endinterface

// File: rtl/cp0_irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the highest set request index.
module cp0_prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [3:0]         id
);

    // NOTE: combinational blocks use blocking assignments with defaults first, so later
    // loop iterations override earlier ones and no latch is inferred.
    always_comb begin
        valid = 1'b0;
        id    = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 exception/interrupt controller: edge-latched sources, mask, fixed priority,
// vectored entry and nested exceptions backed by an EPC/priority stack.
module cp0_irq_ctrl
    import cp0_irq_ctrl_pkg::*;
#(
    parameter int              NUM_SRC    = 8,
    parameter int              NEST_DEPTH = 4,
    parameter logic [XLEN-1:0] VEC_BASE   = 32'h0000_0800,
    parameter int              VEC_SHIFT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    cp0_irq_ctrl_if.slave      bus,
    output logic [3:0]         depth_o,
    output logic               err_o
);

    localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] eligible;
    logic               ie;
    logic               err;
    logic [3:0]         depth;
    logic [3:0]         cur_prio;
    stack_entry_t       stack [NEST_DEPTH];

    logic               win_valid;
    logic [3:0]         win_id;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   push_idx;
    logic               at_zero;
    logic               stack_full;
    logic               win_higher;
    logic               take;
    logic               full_block;
    logic               eret_ok;
    logic               eret_bad;
    logic               wr_status;
    logic               wr_cause;
    logic               wr_epc;

    assign eligible = pending & mask & {NUM_SRC{ie}};

    cp0_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

    assign at_zero    = (depth == 4'd0);
    assign stack_full = (depth == 4'(NEST_DEPTH));
    assign top_idx    = IDX_W'(depth - 4'd1);
    assign push_idx   = IDX_W'(depth);

    // At depth 0 nothing is running, so any winner outranks the (virtual) -1 priority.
    assign win_higher = win_valid && (at_zero || (win_id > cur_prio));
    assign take       = win_higher && !stack_full && !bus.exp_block && !bus.eret_i;
    assign full_block = win_higher &&  stack_full && !bus.exp_block && !bus.eret_i;
    assign eret_ok    = bus.eret_i && !at_zero;
    assign eret_bad   = bus.eret_i &&  at_zero;

    assign wr_status = bus.cp0_we && (bus.cp0_sel == CP0_SEL_STATUS);
    assign wr_cause  = bus.cp0_we && (bus.cp0_sel == CP0_SEL_CAUSE);
    assign wr_epc    = bus.cp0_we && (bus.cp0_sel == CP0_SEL_EPC);

    // Write-1-clear and take-clear first, new rising edges last so a fresh request is never lost.
    always_comb begin
        pending_next = pending;
        if (wr_cause) begin
            pending_next = pending_next & ~bus.cp0_wdata[NUM_SRC-1:0];
        end
        if (take) begin
            pending_next = pending_next & ~(NUM_SRC'(1) << win_id);
        end
        pending_next = pending_next | (src_i & ~src_prev);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_prev <= '0;
            pending  <= '0;
            mask     <= '0;
            ie       <= 1'b0;
            err      <= 1'b0;
            depth    <= 4'd0;
            cur_prio <= 4'd0;
            // NOTE: the stack is a small register file that must read clean after reset,
            // so it is reset explicitly rather than left as uninitialised memory.
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            src_prev <= src_i;
            pending  <= pending_next;

            if (wr_status) begin
                ie   <= bus.cp0_wdata[STATUS_IE_BIT];
                mask <= bus.cp0_wdata[STATUS_MASK_LSB +: NUM_SRC];
            end

            if (eret_bad || full_block) begin
                err <= 1'b1;
            end else if (wr_cause && bus.cp0_wdata[CAUSE_ERR_BIT]) begin
                err <= 1'b0;
            end

            // An EPC write touches the current top; a take pushes one slot above it.
            if (wr_epc && !at_zero) begin
                stack[top_idx].epc <= bus.cp0_wdata;
            end

            if (take) begin
                stack[push_idx] <= '{epc: bus.pc_next_i, prio: cur_prio};
                cur_prio        <= win_id;
                depth           <= depth + 4'd1;
            end else if (eret_ok) begin
                cur_prio <= stack[top_idx].prio;
                depth    <= depth - 4'd1;
            end
        end
    end

    assign bus.exc_take  = take;
    assign bus.exc_eret  = eret_ok;
    assign bus.exc_id    = win_id;
    assign bus.target_pc = take    ? vec_addr(VEC_BASE, VEC_SHIFT, win_id) :
                           eret_ok ? stack[top_idx].epc :
                                     bus.pc_next_i;

    always_comb begin
        bus.cp0_rdata = '0;
        unique case (bus.cp0_sel)
            CP0_SEL_STATUS: begin
                bus.cp0_rdata[STATUS_IE_BIT]               = ie;
                bus.cp0_rdata[STATUS_MASK_LSB +: NUM_SRC] = mask;
            end
            CP0_SEL_CAUSE: begin
                bus.cp0_rdata[NUM_SRC-1:0]           = pending;
                bus.cp0_rdata[CAUSE_PRIO_LSB +: 4]   = at_zero ? 4'd0 : cur_prio;
                bus.cp0_rdata[CAUSE_ERR_BIT]         = err;
            end
            CP0_SEL_EPC:   bus.cp0_rdata = at_zero ? '0 : stack[top_idx].epc;
            CP0_SEL_DEPTH: bus.cp0_rdata = {28'd0, depth};
        endcase
    end

    assign depth_o = depth;
    assign err_o   = err;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboarded bench for cp0_irq_ctrl: directed takes/erets are queued as expectations
// and a negedge monitor matches them against exc_take/exc_eret as they appear.
module tb_cp0_irq_ctrl;
    import cp0_irq_ctrl_pkg::*;

    typedef struct {
        logic        is_eret;
        logic [3:0]  id;
        logic [31:0] target;
        logic [3:0]  depth;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src;
    logic [3:0] depth;
    logic       err;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    cp0_irq_ctrl_if bus ();

    cp0_irq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .src_i   (src),
        .bus     (bus),
        .depth_o (depth),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every take/eret the DUT presents must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (bus.exc_take || bus.exc_eret)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_event: take=%0b eret=%0b id=%0d target=0x%08h",
                         bus.exc_take, bus.exc_eret, bus.exc_id, bus.target_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("event_kind", {30'd0, bus.exc_eret, bus.exc_take}, {30'd0, e.is_eret, !e.is_eret});
                if (!e.is_eret) check("take_id", {28'd0, bus.exc_id}, {28'd0, e.id});
                check("target_pc", bus.target_pc, e.target);
                check("event_depth", {28'd0, depth}, {28'd0, e.depth});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input cp0_sel_e sel, input logic [31:0] exp, input string name);
        bus.cp0_sel = sel;
        #1;
        check(name, bus.cp0_rdata, exp);
    endtask

    task automatic cp0_write(input cp0_sel_e sel, input logic [31:0] data);
        bus.cp0_we    = 1'b1;
        bus.cp0_sel   = sel;
        bus.cp0_wdata = data;
        step();
        bus.cp0_we    = 1'b0;
    endtask

    // Take is expected in the current cycle; the following edge commits it.
    task automatic take_now(input int id, input logic [31:0] pc, input int dep);
        bus.pc_next_i = pc;
        sb.push_back('{is_eret: 1'b0, id: 4'(id), target: 32'h800 + 32'(id) * 32'd16, depth: 4'(dep)});
        step();
        bus.pc_next_i = 32'h0000_4000;
    endtask

    task automatic pulse_take(input int id, input logic [31:0] pc, input int dep);
        src[id] = 1'b1;
        step();
        src[id] = 1'b0;
        take_now(id, pc, dep);
    endtask

    task automatic raise(input int id);
        src[id] = 1'b1;
        step();
        src[id] = 1'b0;
    endtask

    task automatic do_eret(input logic [31:0] target, input int dep);
        bus.eret_i = 1'b1;
        sb.push_back('{is_eret: 1'b1, id: 4'd0, target: target, depth: 4'(dep)});
        step();
        bus.eret_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        src           = '0;
        bus.exp_block = 1'b0;
        bus.eret_i    = 1'b0;
        bus.pc_next_i = 32'h0000_4000;
        bus.cp0_we    = 1'b0;
        bus.cp0_sel   = CP0_SEL_STATUS;
        bus.cp0_wdata = '0;
        repeat (3) step();

        check("rst_take",   {31'd0, bus.exc_take}, 32'd0);
        check("rst_eret",   {31'd0, bus.exc_eret}, 32'd0);
        check("rst_target", bus.target_pc, 32'h0000_4000);
        check("rst_depth",  {28'd0, depth}, 32'd0);
        check("rst_err",    {31'd0, err}, 32'd0);
        rst = 1'b0;
        step();
        read_chk(CP0_SEL_STATUS, 32'h0, "rst_status");
        read_chk(CP0_SEL_CAUSE,  32'h0, "rst_cause");
        read_chk(CP0_SEL_EPC,    32'h0, "rst_epc");

        cp0_write(CP0_SEL_STATUS, 32'h00FF_0001);
        read_chk(CP0_SEL_STATUS, 32'h00FF_0001, "status_rw");

        // Single take of source 3, then nested take of source 5.
        pulse_take(3, 32'h0000_1000, 0);
        read_chk(CP0_SEL_DEPTH, 32'd1, "depth_after_3");
        read_chk(CP0_SEL_EPC, 32'h0000_1000, "epc_after_3");
        read_chk(CP0_SEL_CAUSE, 32'h0300_0000, "cause_after_3");
        pulse_take(5, 32'h0000_2000, 1);
        read_chk(CP0_SEL_DEPTH, 32'd2, "depth_after_5");
        read_chk(CP0_SEL_CAUSE, 32'h0500_0000, "cause_after_5");

        // Lower priority source 2 held until both handlers return.
        raise(2);
        read_chk(CP0_SEL_CAUSE, 32'h0500_0004, "src2_held");
        do_eret(32'h0000_2000, 2);
        read_chk(CP0_SEL_CAUSE, 32'h0300_0004, "prio_restored_3");
        read_chk(CP0_SEL_DEPTH, 32'd1, "depth_after_eret");
        do_eret(32'h0000_1000, 1);
        take_now(2, 32'h0000_3000, 0);
        read_chk(CP0_SEL_DEPTH, 32'd1, "depth_src2");
        do_eret(32'h0000_3000, 1);

        // Simultaneous sources 1 and 6: 6 first, 1 stays pending until the eret.
        src = 8'h42;
        step();
        src = 8'h00;
        take_now(6, 32'h0000_5000, 0);
        read_chk(CP0_SEL_CAUSE, 32'h0600_0002, "src1_pending");
        do_eret(32'h0000_5000, 1);
        take_now(1, 32'h0000_5100, 0);
        read_chk(CP0_SEL_CAUSE, 32'h0100_0000, "src1_cleared");
        do_eret(32'h0000_5100, 1);

        // Fill the stack, then a higher source is refused with err set.
        pulse_take(0, 32'h0000_6000, 0);
        pulse_take(1, 32'h0000_6010, 1);
        pulse_take(2, 32'h0000_6020, 2);
        pulse_take(3, 32'h0000_6030, 3);
        check("depth_full", {28'd0, depth}, 32'd4);
        raise(7);
        step();
        check("err_full", {31'd0, err}, 32'd1);
        read_chk(CP0_SEL_CAUSE, 32'h8300_0080, "cause_full");
        do_eret(32'h0000_6030, 4);
        take_now(7, 32'h0000_7000, 3);
        do_eret(32'h0000_7000, 4);
        do_eret(32'h0000_6020, 3);
        do_eret(32'h0000_6010, 2);
        do_eret(32'h0000_6000, 1);
        check("depth_empty", {28'd0, depth}, 32'd0);
        cp0_write(CP0_SEL_CAUSE, 32'h8000_0000);
        check("err_w1c", {31'd0, err}, 32'd0);

        // Eret at depth 0 is refused and flags err.
        bus.eret_i = 1'b1;
        #1;
        check("eret0_flag",   {31'd0, bus.exc_eret}, 32'd0);
        check("eret0_target", bus.target_pc, 32'h0000_4000);
        step();
        bus.eret_i = 1'b0;
        check("eret0_err", {31'd0, err}, 32'd1);
        cp0_write(CP0_SEL_CAUSE, 32'h8000_0000);
        read_chk(CP0_SEL_CAUSE, 32'h0, "err_cleared");

        // Eret and a higher winner in the same cycle: eret first, take next cycle.
        pulse_take(4, 32'h0000_8000, 0);
        src[6] = 1'b1;
        step();
        src[6] = 1'b0;
        do_eret(32'h0000_8000, 1);
        take_now(6, 32'h0000_8100, 0);
        do_eret(32'h0000_8100, 1);

        // Masked source stays pending and is cleared by write-1-clear.
        cp0_write(CP0_SEL_STATUS, 32'h0000_0001);
        raise(5);
        step();
        read_chk(CP0_SEL_CAUSE, 32'h0000_0020, "masked_pending");
        cp0_write(CP0_SEL_CAUSE, 32'h0000_0020);
        read_chk(CP0_SEL_CAUSE, 32'h0, "pending_w1c");

        // exp_block defers a take until released.
        cp0_write(CP0_SEL_STATUS, 32'h00FF_0001);
        bus.exp_block = 1'b1;
        raise(2);
        step();
        read_chk(CP0_SEL_CAUSE, 32'h0000_0004, "blocked_pending");
        bus.exp_block = 1'b0;
        take_now(2, 32'h0000_9000, 0);
        do_eret(32'h0000_9000, 1);

        step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
